mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001: Parameter TIMEOUT, default 15 (range 1-255), is the number of strobe cycles without MEM_READY before a transaction aborts.
REQ-002: ACLK  input  1  single clock; all logic on rising edge.
REQ-003: RESET  input  1  asynchronous, active-high reset.
REQ-004: I_REQ  input  1  instruction-port read request, held until I_ACK.
REQ-005: I_ADDR  input  32  instruction read address, stable while I_REQ high.
REQ-006: I_ACK  output  1  one-cycle completion pulse, instruction port.
REQ-007: I_RDATA  output  32  instruction read data, valid when I_ACK high.
REQ-008: I_ERR  output  1  timeout flag, valid with I_ACK.
REQ-009: D_REQ  input  1  data-port request, held until D_ACK.
REQ-010: D_WE  input  1  1 = write, 0 = read; stable while D_REQ high.
REQ-011: D_ADDR  input  32  data address.
REQ-012: D_WDATA  input  32  write data.
REQ-013: D_ACK / D_RDATA / D_ERR  output  1/32/1  same meaning as the I_ signals, for the data port.
REQ-014: ADDR  output  32  shared memory address.
REQ-015: DATA_O  output  32  shared write data.
REQ-016: WRSTB  output  1  memory write strobe.
REQ-017: RDSTB  output  1  memory read strobe.
REQ-018: DATA_I  input  32  memory read data, sampled when MEM_READY high.
REQ-019: MEM_READY  input  1  memory completes the strobed access in the current cycle.

Function
REQ-020: FSM states SHALL be IDLE, BUS_I, BUS_D, and DONE; all outputs SHALL be registered.
REQ-021: In IDLE with only I_REQ high, the next state SHALL be BUS_I; with only D_REQ high, it SHALL be BUS_D; with neither, it SHALL stay IDLE.
REQ-022: In IDLE with both requests high, the port not granted most recently SHALL win; a 1-bit last_grant pointer SHALL update on every grant.
REQ-023: On grant, the address, D_WE and D_WDATA SHALL be captured; ADDR, DATA_O and the strobe SHALL be driven from the first BUS_x cycle.
REQ-024: BUS_I SHALL drive RDSTB=1 and WRSTB=0; BUS_D SHALL drive WRSTB=D_WE and RDSTB=!D_WE; the strobes SHALL never both be 1.
REQ-025: DATA_O SHALL be the captured D_WDATA during a BUS_D write, otherwise 0; ADDR SHALL be 0 in IDLE and DONE.
REQ-026: In BUS_x with MEM_READY=1: DATA_I SHALL be captured into x_RDATA (0 for writes), x_ERR=0, and the next state SHALL be DONE.
REQ-027: Wait counter (8-bit) SHALL clear on grant and increment each BUS_x cycle with MEM_READY=0.
REQ-028: When the counter reaches TIMEOUT with MEM_READY=0, the transaction SHALL abort: x_RDATA=0, x_ERR=1, and the next state SHALL be DONE.
REQ-029: MEM_READY=1 in the same cycle the counter reaches TIMEOUT SHALL count as success (ready has priority).
REQ-030: DONE SHALL last exactly one cycle with x_ACK=1 for the granted port only, strobes 0, and requests ignored; the next state SHALL be IDLE.
REQ-031: x_RDATA and x_ERR SHALL hold their value until the next completion on that port.
REQ-032: Latency: request high in IDLE cycle N, strobe in N+1, MEM_READY in N+1 -> ACK in N+2; the minimum period is 3 cycles per transaction.
REQ-033: A requester may present a new request in the cycle after its ACK; back-to-back contention SHALL alternate ports.
REQ-034: A request dropped before ACK is a protocol violation; the granted transaction SHALL still complete and ACK SHALL still pulse.

Reset
REQ-035: RESET SHALL force state IDLE, last_grant=D (I wins the first tie), counter 0, and all outputs 0, asynchronously.
REQ-036: RESET asserted mid-transaction SHALL drop the strobes immediately; no ACK SHALL be issued for the aborted access.

Verification
REQ-037: I_REQ, I_ADDR=0x100, MEM_READY=1 in the strobe cycle -> RDSTB and ADDR=0x100 one cycle later, I_ACK with I_RDATA=DATA_I the following cycle, I_ERR=0.
REQ-038: D write 0x20 <- 0xDEADBEEF, MEM_READY delayed 3 cycles -> WRSTB high for 4 cycles, DATA_O=0xDEADBEEF, D_ACK once, D_RDATA=0.
REQ-039: I_REQ and D_REQ both held continuously after reset -> grant order I,D,I,D, with exactly one ACK per grant.
REQ-040: TIMEOUT=4, MEM_READY tied low -> strobe high for 4 cycles, ACK with ERR=1 and RDATA=0, then IDLE.
REQ-041: MEM_READY=1 exactly on the TIMEOUT cycle -> ERR=0 and read data captured.
REQ-042: RESET pulsed during BUS_D -> strobes 0 asynchronously, no D_ACK, and the next tie is granted to I.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction read / data read-write) arbiter onto one strobed memory bus.
// Round-robin on ties, per-access timeout, every output registered.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        ACLK,
  input  logic        RESET,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic        I_ACK,
  output logic [31:0] I_RDATA,
  output logic        I_ERR,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic        D_ACK,
  output logic [31:0] D_RDATA,
  output logic        D_ERR,
  output logic [31:0] ADDR,
  output logic [31:0] DATA_O,
  output logic        WRSTB,
  output logic        RDSTB,
  input  logic [31:0] DATA_I,
  input  logic        MEM_READY,
  output logic [1:0]  dbg_state
);

  // Handshake: a port raises x_REQ with stable address/data and holds it until
  // x_ACK, a one-cycle pulse carrying x_RDATA/x_ERR; memory finishes a strobed
  // access in any cycle where MEM_READY is high, otherwise the strobe is held.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state, state_nxt;
  logic        last_grant, last_grant_nxt;  // 0 = instruction port, 1 = data port
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic        cur_we, cur_we_nxt;
  logic [31:0] addr_nxt, data_o_nxt, i_rdata_nxt, d_rdata_nxt;
  logic        wrstb_nxt, rdstb_nxt, i_ack_nxt, d_ack_nxt, i_err_nxt, d_err_nxt;
  logic        grant_i, done_abort;

  assign dbg_state = state;

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    wait_cnt_nxt   = wait_cnt;
    cur_we_nxt     = cur_we;
    addr_nxt       = 32'd0;
    data_o_nxt     = 32'd0;
    wrstb_nxt      = 1'b0;
    rdstb_nxt      = 1'b0;
    i_ack_nxt      = 1'b0;
    d_ack_nxt      = 1'b0;
    i_rdata_nxt    = I_RDATA;
    i_err_nxt      = I_ERR;
    d_rdata_nxt    = D_RDATA;
    d_err_nxt      = D_ERR;
    grant_i        = I_REQ && (!D_REQ || last_grant);
    // Ready wins over a timeout landing in the same cycle.
    done_abort     = !MEM_READY && ((wait_cnt + 8'd1) == TIMEOUT_CNT);

    case (state)
      IDLE: begin
        if (I_REQ || D_REQ) begin
          wait_cnt_nxt = 8'd0;
          if (grant_i) begin
            state_nxt      = BUS_I;
            last_grant_nxt = 1'b0;
            cur_we_nxt     = 1'b0;
            addr_nxt       = I_ADDR;
            rdstb_nxt      = 1'b1;
          end else begin
            state_nxt      = BUS_D;
            last_grant_nxt = 1'b1;
            cur_we_nxt     = D_WE;
            addr_nxt       = D_ADDR;
            wrstb_nxt      = D_WE;
            rdstb_nxt      = !D_WE;
            data_o_nxt     = D_WE ? D_WDATA : 32'd0;
          end
        end
      end
      BUS_I, BUS_D: begin
        if (!MEM_READY) wait_cnt_nxt = wait_cnt + 8'd1;
        if (MEM_READY || done_abort) begin
          state_nxt = DONE;
          if (state == BUS_I) begin
            i_ack_nxt   = 1'b1;
            i_err_nxt   = !MEM_READY;
            i_rdata_nxt = MEM_READY ? DATA_I : 32'd0;
          end else begin
            d_ack_nxt   = 1'b1;
            d_err_nxt   = !MEM_READY;
            d_rdata_nxt = (MEM_READY && !cur_we) ? DATA_I : 32'd0;
          end
        end else begin
          // The registered bus outputs are the captured request; keep them.
          addr_nxt   = ADDR;
          data_o_nxt = DATA_O;
          wrstb_nxt  = WRSTB;
          rdstb_nxt  = RDSTB;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      last_grant <= 1'b1;
      wait_cnt   <= 8'd0;
      cur_we     <= 1'b0;
      ADDR       <= 32'd0;
      DATA_O     <= 32'd0;
      WRSTB      <= 1'b0;
      RDSTB      <= 1'b0;
      I_ACK      <= 1'b0;
      I_RDATA    <= 32'd0;
      I_ERR      <= 1'b0;
      D_ACK      <= 1'b0;
      D_RDATA    <= 32'd0;
      D_ERR      <= 1'b0;
    end else begin
      last_grant <= last_grant_nxt;
      wait_cnt   <= wait_cnt_nxt;
      cur_we     <= cur_we_nxt;
      ADDR       <= addr_nxt;
      DATA_O     <= data_o_nxt;
      WRSTB      <= wrstb_nxt;
      RDSTB      <= rdstb_nxt;
      I_ACK      <= i_ack_nxt;
      I_RDATA    <= i_rdata_nxt;
      I_ERR      <= i_err_nxt;
      D_ACK      <= d_ack_nxt;
      D_RDATA    <= d_rdata_nxt;
      D_ERR      <= d_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model predicts every cycle of the bus,
// acks and held results under directed and randomized request/memory traffic.
module tb_mem_arbiter;
  localparam int TIMEOUT = 4;

  logic        ACLK = 1'b0;
  logic        RESET;
  logic        I_REQ, I_ACK, I_ERR;
  logic [31:0] I_ADDR, I_RDATA;
  logic        D_REQ, D_WE, D_ACK, D_ERR;
  logic [31:0] D_ADDR, D_WDATA, D_RDATA;
  logic [31:0] ADDR, DATA_O, DATA_I;
  logic        WRSTB, RDSTB, MEM_READY;
  logic [1:0]  dbg_state;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .ACLK(ACLK), .RESET(RESET),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RDATA(I_RDATA), .I_ERR(I_ERR),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_ACK(D_ACK), .D_RDATA(D_RDATA), .D_ERR(D_ERR),
    .ADDR(ADDR), .DATA_O(DATA_O), .WRSTB(WRSTB), .RDSTB(RDSTB),
    .DATA_I(DATA_I), .MEM_READY(MEM_READY), .dbg_state(dbg_state)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        i_q[$], d_q[$];
  int          delay_q[$];
  int          ack_log[$];
  int          req_pct = 100;
  bit          drop_en = 1'b0;
  int          n_cmp = 0, n_bad = 0;

  // Requester status per port: 0 free, 1 holding request, 2 dropped awaiting ack.
  int          rq_st[2];
  // Reference model: 0 idle, 1 strobing, 2 ack cycle.
  int          m_phase, m_port, m_delay, m_len, m_k, last_m;
  bit          m_ok;
  txn_t        m_t;
  logic [31:0] exp_rdata[2];
  logic        exp_err[2];

  function automatic txn_t mk(input logic we, input logic [31:0] a, input logic [31:0] w);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = w;
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_port = 0; m_k = 0; last_m = 1;
    for (int p = 0; p < 2; p++) begin
      exp_rdata[p] = 32'd0; exp_err[p] = 1'b0; rq_st[p] = 0;
    end
    i_q.delete(); d_q.delete(); delay_q.delete();
  endtask

  task automatic check_cycle();
    logic [31:0] e_addr, e_dout;
    logic [1:0]  e_strb, e_ack;
    e_addr = 32'd0; e_dout = 32'd0; e_strb = 2'b00; e_ack = 2'b00;
    if (m_phase == 1) begin
      e_addr = m_t.addr;
      if (m_port == 1 && m_t.we) begin
        e_strb = 2'b10; e_dout = m_t.wdata;
      end else e_strb = 2'b01;
    end else if (m_phase == 2) e_ack = (m_port == 1) ? 2'b10 : 2'b01;
    check("strobes_wr_rd", {WRSTB, RDSTB}, e_strb);
    check("addr", ADDR, e_addr);
    check("data_o", DATA_O, e_dout);
    check("acks_d_i", {D_ACK, I_ACK}, e_ack);
    check("i_rdata", I_RDATA, exp_rdata[0]);
    check("i_err", I_ERR, exp_err[0]);
    check("d_rdata", D_RDATA, exp_rdata[1]);
    check("d_err", D_ERR, exp_err[1]);
    if (I_ACK) ack_log.push_back(0);
    if (D_ACK) ack_log.push_back(1);
  endtask

  // Drives one cycle of requester and memory stimulus, then advances the model.
  task automatic step();
    txn_t t;
    for (int p = 0; p < 2; p++) begin
      if (m_phase == 2 && m_port == p) begin
        rq_st[p] = 0;
        if (p == 0) I_REQ = 1'b0; else D_REQ = 1'b0;
      end else if (rq_st[p] == 0 && (p == 0 ? i_q.size() : d_q.size()) > 0
                   && $urandom_range(0, 99) < req_pct) begin
        rq_st[p] = 1;
        if (p == 0) begin
          t = i_q.pop_front(); I_ADDR = t.addr; I_REQ = 1'b1;
        end else begin
          t = d_q.pop_front(); D_WE = t.we; D_ADDR = t.addr; D_WDATA = t.wdata; D_REQ = 1'b1;
        end
      end else if (drop_en && rq_st[p] == 1 && m_phase == 1 && m_port == p
                   && $urandom_range(0, 15) == 0) begin
        rq_st[p] = 2;
        if (p == 0) I_REQ = 1'b0; else D_REQ = 1'b0;
      end
    end
    DATA_I    = $urandom;
    MEM_READY = (m_phase == 1) ? (m_k == m_delay) : 1'($urandom_range(0, 1));
    case (m_phase)
      0: if (I_REQ || D_REQ) begin
        if (I_REQ && D_REQ) m_port = (last_m == 1) ? 0 : 1;
        else m_port = I_REQ ? 0 : 1;
        last_m  = m_port;
        m_t     = (m_port == 1) ? mk(D_WE, D_ADDR, D_WDATA) : mk(1'b0, I_ADDR, 32'd0);
        m_delay = (delay_q.size() > 0) ? delay_q.pop_front() : $urandom_range(0, 5);
        m_ok    = (m_delay < TIMEOUT);
        m_len   = m_ok ? m_delay + 1 : TIMEOUT;
        m_k     = 0;
        m_phase = 1;
      end
      1: if (m_k + 1 == m_len) begin
        exp_err[m_port]   = !m_ok;
        exp_rdata[m_port] = (m_ok && !m_t.we) ? DATA_I : 32'd0;
        m_phase = 2;
      end else m_k++;
      default: m_phase = 0;
    endcase
  endtask

  task automatic run(input int min_cyc, input int max_cyc);
    int cyc;
    cyc = 0;
    forever begin
      @(negedge ACLK);
      check_cycle();
      step();
      cyc++;
      if (cyc >= min_cyc && m_phase == 0 && rq_st[0] == 0 && rq_st[1] == 0
          && i_q.size() == 0 && d_q.size() == 0) break;
      if (cyc >= max_cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL run_budget: used %0d cycles, limit %0d", cyc, max_cyc);
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; I_REQ = 1'b0; I_ADDR = 32'd0; D_REQ = 1'b0; D_WE = 1'b0;
    D_ADDR = 32'd0; D_WDATA = 32'd0; DATA_I = 32'd0; MEM_READY = 1'b0;
    model_reset();
    repeat (2) @(negedge ACLK);
    check("reset_ctrl_outs", {I_ACK, I_ERR, D_ACK, D_ERR, WRSTB, RDSTB}, 6'd0);
    check("reset_addr", ADDR, 32'd0);
    check("reset_i_rdata", I_RDATA, 32'd0);
    check("reset_d_rdata", D_RDATA, 32'd0);
    RESET = 1'b0;

    // Both ports requesting continuously from reset: grants alternate, I first.
    ack_log.delete();
    for (int k = 0; k < 2; k++) begin
      i_q.push_back(mk(1'b0, 32'h1000 + 32'(k), 32'd0));
      d_q.push_back(mk(1'($urandom_range(0, 1)), 32'h2000 + 32'(k), $urandom));
    end
    run(1, 100);
    check("contention_ack_count", ack_log.size(), 4);
    for (int k = 0; k < 4 && k < ack_log.size(); k++)
      check("contention_grant_order", ack_log[k], k % 2);

    // Single read with ready in the first strobe cycle.
    i_q.push_back(mk(1'b0, 32'h100, 32'd0)); delay_q.push_back(0);
    run(1, 20);
    // Write with memory ready after three wait cycles.
    d_q.push_back(mk(1'b1, 32'h20, 32'hDEADBEEF)); delay_q.push_back(3);
    run(1, 20);
    check("write_d_rdata_zero", D_RDATA, 32'd0);
    check("write_d_err", D_ERR, 1'b0);
    // Memory never ready: abort after TIMEOUT strobe cycles.
    i_q.push_back(mk(1'b0, 32'h44, 32'd0)); delay_q.push_back(99);
    run(1, 20);
    check("timeout_i_err", I_ERR, 1'b1);
    check("timeout_i_rdata", I_RDATA, 32'd0);
    // Ready exactly on the TIMEOUT-th strobe cycle counts as success.
    d_q.push_back(mk(1'b0, 32'h88, 32'd0)); delay_q.push_back(TIMEOUT - 1);
    run(1, 20);
    check("edge_ready_d_err", D_ERR, 1'b0);

    // Randomized traffic with idle gaps, random memory latency and dropped requests.
    req_pct = 50; drop_en = 1'b1;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 1) == 0) i_q.push_back(mk(1'b0, $urandom, 32'd0));
      else d_q.push_back(mk(1'($urandom_range(0, 1)), $urandom, $urandom));
    end
    run(1, 4000);
    req_pct = 100; drop_en = 1'b0;

    // Reset in the middle of a data write.
    d_q.push_back(mk(1'b1, 32'h40, 32'h12345678)); delay_q.push_back(99);
    @(negedge ACLK); check_cycle(); step();
    @(negedge ACLK); check_cycle(); step();
    #2 RESET = 1'b1;
    #1;
    check("async_reset_strobes", {WRSTB, RDSTB}, 2'b00);
    check("async_reset_addr", ADDR, 32'd0);
    check("async_reset_data_o", DATA_O, 32'd0);
    model_reset();
    I_REQ = 1'b0; D_REQ = 1'b0;
    @(negedge ACLK);
    RESET = 1'b0;
    ack_log.delete();
    run(6, 20);
    check("no_ack_after_reset", ack_log.size(), 0);
    // First tie after reset goes to the instruction port.
    i_q.push_back(mk(1'b0, 32'h300, 32'd0));
    d_q.push_back(mk(1'b0, 32'h400, 32'd0));
    run(1, 40);
    check("post_reset_ack_count", ack_log.size(), 2);
    if (ack_log.size() > 0) check("post_reset_tie_to_i", ack_log[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
